// File: rtl/pipe_pkg.sv
// pipe_pkg: constants, FSM state type and lane helpers shared by the PIPE MAC transmit path.
// Optional feature: define PIPE_MAC_TX_SKP_EN to add the SKP state and ordered-set constants.
package pipe_pkg;

   localparam logic [7:0] K28_5    = 8'hBC;  // COM
   localparam logic [7:0] K28_0    = 8'h1C;  // SKP
   localparam logic [7:0] IDLE_SYM = 8'h00;

   localparam logic [5:0] DBW_8  = 6'd8;
   localparam logic [5:0] DBW_16 = 6'd16;
   localparam logic [5:0] DBW_32 = 6'd32;

`ifdef PIPE_MAC_TX_SKP_EN
   typedef enum logic [1:0] {IDLE, DATA, SKP} pipe_state_t;

   // COM first in lane 0, then three SKP symbols, all K
   localparam logic [31:0] SKP_OS_WORD = {K28_0, K28_0, K28_0, K28_5};
   localparam logic [3:0]  SKP_OS_K    = 4'hF;
`else
   typedef enum logic [1:0] {IDLE, DATA} pipe_state_t;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  k;
   } lane_chunk_t;

   // lanes per PCLK for a DataBusWidth code; unknown codes fall back to one byte
   function automatic logic [2:0] lanes_of(input logic [5:0] dbw);
      logic [2:0] l;
      case (dbw)
         DBW_8:   l = 3'd1;
         DBW_16:  l = 3'd2;
         DBW_32:  l = 3'd4;
         default: l = 3'd1;
      endcase
      return l;
   endfunction

   // index of the final chunk of a 4-byte unit at the given lane count
   function automatic logic [1:0] last_idx(input logic [2:0] lanes);
      logic [1:0] li;
      case (lanes)
         3'd4:    li = 2'd0;
         3'd2:    li = 2'd1;
         default: li = 2'd3;
      endcase
      return li;
   endfunction

   // chunk idx of a 4-byte unit, placed in the low lanes with unused lanes zeroed
   function automatic lane_chunk_t chunk_of(input logic [31:0] word, input logic [3:0] k,
                                            input logic [1:0] idx, input logic [2:0] lanes);
      lane_chunk_t c;
      logic [31:0] dsh;
      logic [3:0]  ksh;
      c = '0;
      case (lanes)
         3'd4: begin
            c.data = word;
            c.k    = k;
         end
         3'd2: begin
            dsh    = word >> {idx, 4'b0000};
            ksh    = k >> {idx, 1'b0};
            c.data = {16'h0000, dsh[15:0]};
            c.k    = {2'b00, ksh[1:0]};
         end
         default: begin
            dsh    = word >> {idx, 3'b000};
            ksh    = k >> idx;
            c.data = {24'h000000, dsh[7:0]};
            c.k    = {3'b000, ksh[0]};
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_skp_timer.sv
// pipe_skp_timer: saturating transmitted-symbol counter that requests a SKP ordered set.
// Only instantiated when PIPE_MAC_TX_SKP_EN is defined.
module pipe_skp_timer #(
   parameter int SKP_INTERVAL = 1180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] inc,
   input  logic       clr,
   output logic       pending
);

   localparam int unsigned CW    = $clog2(SKP_INTERVAL + 1);
   localparam logic [CW-1:0] LIMIT = CW'(SKP_INTERVAL);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   sum;

   // add the symbols loaded this cycle, saturating at the interval; clear wins
   always_comb begin
      sum = {1'b0, cnt_q} + (CW+1)'(inc);
      if (clr) begin
         cnt_d = '0;
      end else if (sum >= {1'b0, LIMIT}) begin
         cnt_d = LIMIT;
      end else begin
         cnt_d = sum[CW-1:0];
      end
   end

   // symbol counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pending = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_mac_tx.sv
// pipe_mac_tx: serialises 32-bit link-layer words onto a 1/2/4-lane PIPE TX bus,
// filling gaps with logical idle. Define PIPE_MAC_TX_SKP_EN to insert SKP ordered
// sets every SKP_INTERVAL transmitted symbols.
module pipe_mac_tx
   import pipe_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180
) (
   input  logic        PCLK,
   input  logic        Rst,
   input  logic [5:0]  DataBusWidth,
   input  logic [31:0] Tx_Word,
   input  logic [3:0]  Tx_WordK,
   input  logic        Tx_Valid,
   output logic        Tx_Ready,
   output logic [31:0] MAC_TX_Data,
   output logic [3:0]  MAC_TX_DataK,
   output logic        MAC_Data_En
);

   pipe_state_t state_q, state_d;
   logic [31:0] word_q, word_d;
   logic [3:0]  wordk_q, wordk_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  lanes_q, lanes_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  datak_q, datak_d;
   logic        en_q, en_d;
   logic        run_q, run_d;
   logic        unit_done, ready, accept;
   lane_chunk_t chunk;

`ifdef PIPE_MAC_TX_SKP_EN
   logic        skp_pending, skp_clr;

   pipe_skp_timer #(
      .SKP_INTERVAL(SKP_INTERVAL)
   ) u_skp_timer (
      .clk    (PCLK),
      .rst    (Rst),
      .inc    (lanes_d),
      .clr    (skp_clr),
      .pending(skp_pending)
   );
`else
   // The interval only sizes the SKP timer, which this build does not contain.
   if (SKP_INTERVAL < 1) begin : g_interval_unused
   end
`endif

   // the unit on the bus ends this cycle: idle is one chunk, words and ordered sets end on their last chunk
   always_comb begin
      unit_done = (state_q == IDLE) || (idx_q == last_idx(lanes_q));
`ifdef PIPE_MAC_TX_SKP_EN
      ready     = run_q && unit_done && !skp_pending;
`else
      ready     = run_q && unit_done;
`endif
      accept    = Tx_Valid && ready;
   end

   // state register: FSM state, held word, chunk index and latched lane count
   always_ff @(posedge PCLK or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         wordk_q <= '0;
         idx_q   <= '0;
         lanes_q <= 3'd1;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         wordk_q <= wordk_d;
         idx_q   <= idx_d;
         lanes_q <= lanes_d;
      end
   end

   // next state: step through the current unit, choose the next one at a boundary (SKP beats a new word)
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      wordk_d = wordk_q;
      idx_d   = idx_q + 2'd1;
      lanes_d = lanes_q;
      if (unit_done) begin
         lanes_d = lanes_of(DataBusWidth);
         idx_d   = '0;
         state_d = IDLE;
         word_d  = '0;
         wordk_d = '0;
         if (accept) begin
            state_d = DATA;
            word_d  = Tx_Word;
            wordk_d = Tx_WordK;
         end
`ifdef PIPE_MAC_TX_SKP_EN
         if (skp_pending) begin
            state_d = SKP;
         end
`endif
      end
`ifdef PIPE_MAC_TX_SKP_EN
      // counter restarts as the final chunk of the ordered set is loaded
      skp_clr = (state_d == SKP) && (idx_d == last_idx(lanes_d));
`endif
   end

   // outputs: lane contents of the chunk being loaded for the next cycle
   always_comb begin
      chunk = chunk_of({4{IDLE_SYM}}, 4'h0, idx_d, lanes_d);
      case (state_d)
         DATA: chunk = chunk_of(word_d, wordk_d, idx_d, lanes_d);
`ifdef PIPE_MAC_TX_SKP_EN
         SKP:  chunk = chunk_of(SKP_OS_WORD, SKP_OS_K, idx_d, lanes_d);
`endif
         default: ;
      endcase
      data_d  = chunk.data;
      datak_d = chunk.k;
      en_d    = 1'b1;
      run_d   = 1'b1;
   end

   // registered PHY-side outputs and the post-reset run flag
   always_ff @(posedge PCLK or posedge Rst) begin
      if (Rst) begin
         data_q  <= '0;
         datak_q <= '0;
         en_q    <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         datak_q <= datak_d;
         en_q    <= en_d;
         run_q   <= run_d;
      end
   end

   assign Tx_Ready     = ready;
   assign MAC_TX_Data  = data_q;
   assign MAC_TX_DataK = datak_q;
   assign MAC_Data_En  = en_q;

endmodule

// File: tb/tb_pipe_mac_tx.sv
// tb_pipe_mac_tx: random and directed traffic against a symbol-queue reference model.
// Builds with or without PIPE_MAC_TX_SKP_EN; SKP_INTERVAL is overridden to 16.
module tb_pipe_mac_tx;
   import pipe_pkg::*;

   localparam int SKP_IV = 16;
`ifdef PIPE_MAC_TX_SKP_EN
   localparam bit SKP_ON = 1'b1;
`else
   localparam bit SKP_ON = 1'b0;
`endif

   logic        PCLK = 1'b0;
   logic        Rst = 1'b1;
   logic [5:0]  DataBusWidth = DBW_32;
   logic [31:0] Tx_Word = '0;
   logic [3:0]  Tx_WordK = '0;
   logic        Tx_Valid = 1'b0;
   logic        Tx_Ready;
   logic [31:0] MAC_TX_Data;
   logic [3:0]  MAC_TX_DataK;
   logic        MAC_Data_En;

   always #5 PCLK = ~PCLK;

   pipe_mac_tx #(
      .SKP_INTERVAL(SKP_IV)
   ) dut (
      .PCLK        (PCLK),
      .Rst         (Rst),
      .DataBusWidth(DataBusWidth),
      .Tx_Word     (Tx_Word),
      .Tx_WordK    (Tx_WordK),
      .Tx_Valid    (Tx_Valid),
      .Tx_Ready    (Tx_Ready),
      .MAC_TX_Data (MAC_TX_Data),
      .MAC_TX_DataK(MAC_TX_DataK),
      .MAC_Data_En (MAC_Data_En)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned got_kcom = 0;
   int unsigned exp_kcom = 0;

   // reference model: symbols {K, byte} of the unit on the bus, current chunk first
   logic [8:0] m_q[$];
   bit         m_skp = 1'b0;
   int         m_cnt = 0;   // non-SKP symbols put on the bus since the last ordered set
   int         m_L = 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lanes_for(input logic [5:0] bw);
      if (bw == DBW_32) return 4;
      if (bw == DBW_16) return 2;
      return 1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_skp = 1'b0;
      m_cnt = 0;
      m_L   = 1;
   endtask

   // one PCLK: compare at the falling edge, then drive inputs and advance the model past the rising edge
   task automatic step(input logic v, input logic [31:0] w, input logic [3:0] k,
                       input logic [5:0] bw, output bit acc);
      logic [31:0] exp_d;
      logic [3:0]  exp_k;
      logic        exp_en, exp_rdy;
      @(negedge PCLK);
      exp_d   = '0;
      exp_k   = '0;
      exp_en  = (m_q.size() != 0);
      exp_rdy = 1'b0;
      if (exp_en) begin
         for (int i = 0; i < m_L; i++) begin
            exp_d[8*i +: 8] = m_q[i][7:0];
            exp_k[i]        = m_q[i][8];
         end
         exp_rdy = (m_q.size() == m_L) && !(SKP_ON && m_cnt >= SKP_IV);
      end
      for (int i = 0; i < 4; i++) begin
         if (MAC_TX_DataK[i] && MAC_TX_Data[8*i +: 8] == K28_5) got_kcom++;
      end
      check_eq("data", MAC_TX_Data, exp_d);
      check_eq("datak", {28'h0, MAC_TX_DataK}, {28'h0, exp_k});
      check_eq("data_en", {31'h0, MAC_Data_En}, {31'h0, exp_en});
      check_eq("tx_ready", {31'h0, Tx_Ready}, {31'h0, exp_rdy});

      Tx_Valid     = v;
      Tx_Word      = w;
      Tx_WordK     = k;
      DataBusWidth = bw;
      acc = v && exp_rdy;

      if (exp_en) repeat (m_L) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
         m_L = lanes_for(bw);
         if (SKP_ON && m_cnt >= SKP_IV) begin
            m_q.push_back({1'b1, K28_5});
            repeat (3) m_q.push_back({1'b1, K28_0});
            m_skp = 1'b1;
            m_cnt = 0;
            exp_kcom++;
         end else begin
            m_skp = 1'b0;
            if (acc) begin
               for (int i = 0; i < 4; i++) begin
                  m_q.push_back({k[i], w[8*i +: 8]});
                  if (k[i] && w[8*i +: 8] == K28_5) exp_kcom++;
               end
            end else begin
               repeat (m_L) m_q.push_back({1'b0, IDLE_SYM});
            end
            m_cnt += m_L;
         end
      end else if (!m_skp) begin
         m_cnt += m_L;
      end
   endtask

   // hold a word on the bus until it is taken, within a bounded number of cycles
   task automatic offer(input logic [31:0] w, input logic [3:0] k, input logic [5:0] bw);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 40) begin
         step(1'b1, w, k, bw, acc);
         n++;
      end
      check_eq("accepted", {31'h0, acc}, 32'h1);
   endtask

   function automatic logic [5:0] pick_width();
      case ($urandom_range(0, 3))
         0:       return DBW_8;
         1:       return DBW_16;
         2:       return DBW_32;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc, held;
      logic        v;
      logic [31:0] w, bytes;
      logic [3:0]  k;
      logic [5:0]  bw;

      // outputs held low during reset
      repeat (3) @(negedge PCLK);
      check_eq("rst_data", MAC_TX_Data, 32'h0);
      check_eq("rst_datak", {28'h0, MAC_TX_DataK}, 32'h0);
      check_eq("rst_en", {31'h0, MAC_Data_En}, 32'h0);
      check_eq("rst_ready", {31'h0, Tx_Ready}, 32'h0);
      @(posedge PCLK);
      #1 Rst = 1'b0;
      model_reset();

      // idle at width 32, then one full-width word
      repeat (4) step(1'b0, '0, '0, DBW_32, acc);
      offer(32'h44332211, 4'h0, DBW_32);
      step(1'b0, '0, '0, DBW_32, acc);
      check_eq("w32_word", MAC_TX_Data, 32'h44332211);
      check_eq("w32_k", {28'h0, MAC_TX_DataK}, 32'h0);

      // byte-wide word with a K flag on byte 0
      offer(32'hDDCCBBAA, 4'b0001, DBW_8);
      bytes = 32'hDDCCBBAA;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, '0, DBW_8, acc);
         check_eq("w8_byte", MAC_TX_Data, {24'h0, bytes[8*i +: 8]});
         check_eq("w8_k", {28'h0, MAC_TX_DataK}, (i == 0) ? 32'h1 : 32'h0);
         if (i < 3) check_eq("w8_ready_mid", {31'h0, Tx_Ready}, 32'h0);
      end

      // reset during the second chunk of a byte-wide word
      offer(32'h87654321, 4'h0, DBW_8);
      step(1'b0, '0, '0, DBW_8, acc);
      step(1'b0, '0, '0, DBW_8, acc);
      Rst = 1'b1;
      #1;
      check_eq("arst_data", MAC_TX_Data, 32'h0);
      check_eq("arst_datak", {28'h0, MAC_TX_DataK}, 32'h0);
      check_eq("arst_en", {31'h0, MAC_Data_En}, 32'h0);
      check_eq("arst_ready", {31'h0, Tx_Ready}, 32'h0);
      repeat (2) @(posedge PCLK);
      #1 Rst = 1'b0;
      model_reset();
      repeat (8) step(1'b0, '0, '0, DBW_8, acc);

      // idle stream at width 32
      repeat (40) step(1'b0, '0, '0, DBW_32, acc);

      // continuous traffic at width 16
      held = 1'b0;
      w    = '0;
      for (int c = 0; c < 200; c++) begin
         if (!held) w = $urandom;
         step(1'b1, w, 4'h0, DBW_16, acc);
         held = !acc;
      end

      // random traffic, widths changing at arbitrary points
      held = 1'b0;
      v    = 1'b0;
      k    = '0;
      bw   = DBW_16;
      for (int c = 0; c < 3000; c++) begin
         if (!held) begin
            v = ($urandom_range(0, 3) != 0);
            w = $urandom;
            k = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0) begin
               w[7:0] = K28_5;
               k[0]   = 1'b1;
            end
         end
         if ($urandom_range(0, 39) == 0) bw = pick_width();
         step(v, w, k, bw, acc);
         held = v && !acc;
      end
      step(1'b0, '0, '0, DBW_32, acc);

      check_eq("kcom_count", got_kcom, exp_kcom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_mac_tx.md
PIPE_MAC_TX -- requirements
Module: pipe_mac_tx

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 1180, meaning the number of transmitted symbols between SKP ordered sets.
REQ-002 SHALL have port PCLK  input  1  PIPE parallel clock; all logic is on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port DataBusWidth  input  6  symbols per PCLK: 8 = 1 byte, 16 = 2 bytes, 32 = 4 bytes; any other value is treated as 8.
REQ-005 SHALL have port Tx_Word  input  32  payload word from the link layer; byte 0 is [7:0] and is sent first.
REQ-006 SHALL have port Tx_WordK  input  4  per-byte K-symbol flags for Tx_Word.
REQ-007 SHALL have port Tx_Valid  input  1  Tx_Word/Tx_WordK are valid.
REQ-008 SHALL have port Tx_Ready  output  1  the word is accepted in a cycle where Tx_Valid and Tx_Ready are both high.
REQ-009 SHALL have port MAC_TX_Data  output  32  symbols to the PHY; unused upper lanes are driven 0.
REQ-010 SHALL have port MAC_TX_DataK  output  4  per-lane K flags; unused lanes are driven 0.
REQ-011 SHALL have port MAC_Data_En  output  1  MAC_TX_Data is valid.

Function
REQ-012 SHALL use a state machine with states IDLE, DATA and SKP.
REQ-013 SHALL, in IDLE with no held word, drive logical idle: all active lanes 8'h00, K = 0, MAC_Data_En = 1.
REQ-014 SHALL register all outputs, so a word accepted in cycle n drives its first chunk in cycle n+1.
REQ-015 SHALL emit each word as 4/L chunks of L bytes, in byte order, where L = DataBusWidth/8 (4, 2 or 1 PCLK cycles per word).
REQ-016 SHALL hold one word internally and raise Tx_Ready only when the held word's last chunk is being driven (or no word is held) and no SKP is pending.
REQ-017 SHALL support back-to-back acceptance without idle gaps: at L = 4, one word per cycle at full throughput.
REQ-018 SHALL count transmitted symbols (data, idle and SKP) with a counter that saturates at SKP_INTERVAL.
REQ-019 SHALL, once the counter reaches SKP_INTERVAL, set skp_pending, deassert Tx_Ready, finish the current word and then enter SKP.
REQ-020 SHALL, in SKP, send the ordered set COM (8'hBC, K = 1) followed by three SKP symbols (8'h1C, K = 1), as 4/L chunks, then clear the counter and return to DATA (word held) or IDLE.
REQ-021 SHALL, if the counter reaches SKP_INTERVAL in the same cycle a word is offered, give the SKP priority; the word waits with Tx_Valid held.
REQ-022 SHALL sample DataBusWidth only at word or ordered-set boundaries; a change mid-word takes effect at the next boundary.
REQ-023 SHALL pass Tx_WordK through unmodified; the block performs no symbol validity checking.

Reset
REQ-024 SHALL, while Rst is high, hold MAC_TX_Data = 0, MAC_TX_DataK = 0, MAC_Data_En = 0, Tx_Ready = 0, state = IDLE, counter = 0 and the held word cleared.
REQ-025 SHALL, on Rst assertion mid-word or mid-SKP, discard all partial data immediately (asynchronously).
REQ-026 SHALL raise MAC_Data_En and Tx_Ready on the first PCLK edge after Rst deasserts.

Configuration
REQ-027 SHALL, with macro PIPE_MAC_TX_SKP_EN defined, implement the SKP counter, the SKP state and REQ-018 to REQ-021.
REQ-028 SHALL, without PIPE_MAC_TX_SKP_EN, omit the counter and the SKP state, never insert ordered sets, and drop the skp_pending term from Tx_Ready.

Structure
REQ-029 SHALL take the constants K28_5 = 8'hBC, K28_0 = 8'h1C, IDLE_SYM = 8'h00 and the width encodings 8/16/32 from the shared package pipe_pkg, along with the state enum type.
REQ-030 SHALL place the symbol counter and pending flag in one sub-module, pipe_skp_timer, which is instantiated only under PIPE_MAC_TX_SKP_EN.

Verification
REQ-031 SHALL cover: DataBusWidth = 32, Tx_Word = 32'h44332211 accepted at cycle 5 -> MAC_TX_Data = 32'h44332211 with K = 4'h0 at cycle 6.
REQ-032 SHALL cover: DataBusWidth = 8, word 32'hDDCCBBAA with K = 4'b0001 -> bytes AA(K=1), BB, CC, DD on 4 consecutive cycles, with Tx_Ready high only on the DD cycle.
REQ-033 SHALL cover: SKP_INTERVAL = 16, width 16, continuous Tx_Valid -> after 16 symbols, chunks {1C,BC} and {1C,1C} with K = 2'b11, Tx_Ready low for 2 cycles, and no payload byte lost or duplicated.
REQ-034 SHALL cover: Tx_Valid low after reset at width 32 -> MAC_TX_Data = 0 with MAC_Data_En = 1 every cycle; with SKP enabled, the SKP set appears every 16 symbols.
REQ-035 SHALL cover: Rst asserted during the second chunk of a width-8 word -> outputs 0 in the same cycle, and after release the idle stream restarts with no leftover bytes.
REQ-036 SHALL cover: build without PIPE_MAC_TX_SKP_EN plus 5000 symbols of traffic -> no 8'hBC or 8'h1C with K = 1 appears unless it is present in Tx_Word.
